fibo_capture_fifo: RTL and testbench

//  Downstream stage of the Fibonacci generator: samples its fibo_series output every

---
 rtl/fibo_capture_fifo.sv | 121 ++++++++++++
 tb/tb_fibo_capture_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_capture_fifo.sv
// Capture FIFO behind the Fibonacci generator, drained over valid/ready.
// Define FIBO_CHK_EN to build the f[n] = f[n-1] + f[n-2] recurrence checker.
module fibo_capture_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic [W-1:0]             fibo_in,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         term_count,
  output logic                     drop_flag,
  output logic                     seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    PRIME1,
    PRIME2,
    RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    if (capture_en) begin
      unique case (state)
        IDLE:    state_nx = PRIME1;
        PRIME1:  state_nx = PRIME2;
        PRIME2:  state_nx = RUN;
        RUN:     state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign push       = capture_en & ((count < CW'(DEPTH)) | pop);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= fibo_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      term_count <= '0;
      drop_flag  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && term_count != '1)
        term_count <= term_count + CNT_W'(1);
      if (capture_en && !push)
        drop_flag <= 1'b1;
    end
  end

`ifdef FIBO_CHK_EN
  logic [W-1:0] h1;
  logic [W-1:0] h2;
  logic [W-1:0] sum;
  logic         chk;

  // Sum is W bits wide so the carry drops, as in the generator's adder.
  assign sum = h1 + h2;
  assign chk = capture_en & ((state == PRIME2) | (state == RUN));

  always_ff @(posedge clk) begin
    if (reset) begin
      h1      <= '0;
      h2      <= '0;
      seq_err <= 1'b0;
    end else if (!capture_en) begin
      h1 <= '0;
      h2 <= '0;
    end else begin
      h1 <= fibo_in;
      h2 <= (state == IDLE) ? '0 : h1;
      if (chk && fibo_in != sum)
        seq_err <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fibo_capture_fifo.sv
// Directed testbench for fibo_capture_fifo.
// Build with or without FIBO_CHK_EN; seq_err expectations follow the macro.
module tb_fibo_capture_fifo;

  localparam int W     = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
`ifdef FIBO_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             capture_en;
  logic [W-1:0]     fibo_in;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       fifo_count;
  logic [CNT_W-1:0] term_count;
  logic             drop_flag;
  logic             seq_err;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] got [$];
  logic [W-1:0] fibs [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 5, 2};
  logic         chk_exp;

  always #5 clk = ~clk;

  fibo_capture_fifo #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .fibo_in    (fibo_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .term_count (term_count),
    .drop_flag  (drop_flag),
    .seq_err    (seq_err)
  );

  task automatic cyc(input logic ce, input logic [W-1:0] fi,
                     input logic rdy);
    capture_en = ce;
    fibo_in    = fi;
    out_ready  = rdy;
    #1;
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    capture_en = 1'b0;
    out_ready  = 1'b0;
    fibo_in    = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%0d want 0 0",
               out_valid, out_data);
    end
    checks++;
    if (fifo_count !== 4'd0 || term_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: count=%0d terms=%0d want 0 0",
               fifo_count, term_count);
    end
    checks++;
    if (drop_flag !== 1'b0 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: drop=%b seq=%b want 0 0",
               drop_flag, seq_err);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, fibs[i], 1'b1);
    cyc(1'b0, '0, 1'b1);
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL stream_len: got %0d want 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i] !== fibs[i]) begin
        errors++;
        $display("FAIL stream[%0d]: got %0d want %0d", i, got[i], fibs[i]);
      end
    end
    checks++;
    if (term_count !== 8'd6 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL stream_stat: terms=%0d seq=%b want 6 0",
               term_count, seq_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, fibs[i], 1'b0);
    cyc(1'b0, '0, 1'b0);
    checks++;
    if (fifo_count !== 4'd8 || drop_flag !== 1'b1) begin
      errors++;
      $display("FAIL ovf_state: count=%0d drop=%b want 8 1",
               fifo_count, drop_flag);
    end
    checks++;
    if (term_count !== 8'd8) begin
      errors++;
      $display("FAIL ovf_terms: got %0d want 8", term_count);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
    checks++;
    if (got.size() != 8 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL ovf_drain: n=%0d count=%0d want 8 0",
               got.size(), fifo_count);
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++;
      if (got[i] !== fibs[i]) begin
        errors++;
        $display("FAIL ovf[%0d]: got %0d want %0d", i, got[i], fibs[i]);
      end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, fibs[i], 1'b0);
    cyc(1'b1, fibs[8], 1'b1);
    checks++;
    if (fifo_count !== 4'd8 || drop_flag !== 1'b0) begin
      errors++;
      $display("FAIL full_pp: count=%0d drop=%b want 8 0",
               fifo_count, drop_flag);
    end
    checks++;
    if (out_data !== 4'd1 || term_count !== 8'd9) begin
      errors++;
      $display("FAIL full_head: data=%0d terms=%0d want 1 9",
               out_data, term_count);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
    checks++;
    if (got.size() != 9) begin
      errors++;
      $display("FAIL full_len: got %0d want 9", got.size());
    end else begin
      checks++;
      if (got[7] !== 4'd13 || got[8] !== 4'd5) begin
        errors++;
        $display("FAIL full_order: tail %0d,%0d want 13,5",
                 got[7], got[8]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, fibs[i], 1'b1);
    cyc(1'b0, '0, 1'b1);
    checks++;
    if (got.size() != 10) begin
      errors++;
      $display("FAIL wrap_len: got %0d want 10", got.size());
    end else begin
      checks++;
      if (got[8] !== 4'd5 || got[9] !== 4'd2) begin
        errors++;
        $display("FAIL wrap_terms: got %0d,%0d want 5,2", got[8], got[9]);
      end
    end
    checks++;
    if (seq_err !== 1'b0 || drop_flag !== 1'b0) begin
      errors++;
      $display("FAIL wrap_flags: seq=%b drop=%b want 0 0",
               seq_err, drop_flag);
    end
  endtask

  task automatic test_seq_err();
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, fibs[i], 1'b1);
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL seq_pre: got %b want 0", seq_err);
    end
    cyc(1'b1, 4'd7, 1'b1);
    checks++;
    if (seq_err !== chk_exp) begin
      errors++;
      $display("FAIL seq_hit: got %b want %b", seq_err, chk_exp);
    end
    cyc(1'b1, 4'd12, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    checks++;
    if (seq_err !== chk_exp) begin
      errors++;
      $display("FAIL seq_hold: got %b want %b", seq_err, chk_exp);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, fibs[i], 1'b0);
    cyc(1'b1, 4'd9, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, fibs[i], 1'b0);
    checks++;
    if (fifo_count !== 4'd8 || drop_flag !== 1'b1 || seq_err !== chk_exp) begin
      errors++;
      $display("FAIL mr_pre: count=%0d drop=%b seq=%b want 8 1 %b",
               fifo_count, drop_flag, seq_err, chk_exp);
    end
    reset      = 1'b1;
    capture_en = 1'b1;
    fibo_in    = 4'd3;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL mr_fifo: valid=%b count=%0d want 0 0",
               out_valid, fifo_count);
    end
    checks++;
    if (drop_flag !== 1'b0 || seq_err !== 1'b0 || term_count !== 8'd0) begin
      errors++;
      $display("FAIL mr_flags: drop=%b seq=%b terms=%0d want 0 0 0",
               drop_flag, seq_err, term_count);
    end
    cyc(1'b1, 4'd9, 1'b0);
    cyc(1'b1, 4'd4, 1'b0);
    cyc(1'b1, 4'd13, 1'b0);
    cyc(1'b0, '0, 1'b0);
    checks++;
    if (seq_err !== 1'b0 || fifo_count !== 4'd3) begin
      errors++;
      $display("FAIL mr_prime: seq=%b count=%0d want 0 3",
               seq_err, fifo_count);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL mr_len: got %0d want 3", got.size());
    end else begin
      checks++;
      if (got[0] !== 4'd9 || got[1] !== 4'd4 || got[2] !== 4'd13) begin
        errors++;
        $display("FAIL mr_order: got %0d,%0d,%0d want 9,4,13",
                 got[0], got[1], got[2]);
      end
    end
  endtask

  initial begin
    chk_exp = CHK;
    test_reset();
    test_stream();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_seq_err();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
